bcd_counter_0to99: RTL and testbench
====================================

# bcd_counter_0to99

Two-digit synchronous BCD up-counter (00 → LIMIT) gated by the same `Bs`/`Vs` request inputs and `Error` abort used by the 9-to-0 countdown stage. It is the counting-up counterpart of the countdown: the countdown measures remaining time, and this block measures elapsed units (cycles, coins, presses). It feeds the display decoder with two BCD digits and drives a `done` flag into the control FSM. All outputs are registered.

## Interface
Parameters:
- `LIMIT`, default 99: terminal count, decimal; legal range 1–99. Decoded internally to tens/units BCD.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Bs`  in  1  count request A.
- `Vs`  in  1  count request B; enable `en = (Bs | Vs) & !Error`.
- `Error`  in  1  synchronous abort/clear; highest priority after `reset`.
- `bcd_units`  out  4  units digit, 0–9.
- `bcd_tens`  out  4  tens digit, 0–9.
- `done`  out  1  high while in DONE.
- `carry`  out  1  one-cycle pulse when units wraps 9→0 on an increment.
- `state`  out  2  FSM state for debug: IDLE=00, COUNT=01, DONE=10.

## Operation
- Reset (async): state IDLE, digits 00, `done`=0, `carry`=0; held as long as `reset`=1.
- Priority per edge: `reset` > `Error` > `en` > hold.
- IDLE: value is 00. If `en`, then value=01 and the next state is COUNT. If `LIMIT`==1, the next state is DONE instead. Otherwise hold.
- COUNT:
  - `Error` → value 00, next state IDLE.
  - `en` → BCD increment. Units 9 → units 0 and tens+1, with `carry`=1 for that cycle. If the new value equals `LIMIT`, the next state is DONE.
  - Otherwise hold value and state.
- DONE: value holds at `LIMIT`; `done`=1.
  - `Error` → value 00, IDLE.
  - Other behaviour depends on `WRAP_EN` (see Configuration).
- Digits never take values 10–15. Tens never exceeds `LIMIT` tens. The count never passes `LIMIT`.
- `Bs`=`Vs`=1 behaves exactly like a single request: one increment per edge.
- `carry` is 0 on every cycle not caused by a units 9→0 increment, including Error clears and wrap to 00.

## Timing
- Latency: an input sampled at edge N is reflected on the outputs after edge N (one register stage). No combinational input→output path.
- `done` rises on the same edge that loads `LIMIT`.
- `carry` is high for exactly one cycle, coincident with the digits showing X0.
- With `Error` asserted at edge N, the outputs are 00/IDLE after edge N regardless of `Bs`/`Vs`. Counting resumes at the first edge where `en`=1.
- `reset` asserted mid-count clears the outputs immediately, without waiting for `clock`. After deassertion, the first enabled edge yields 01.

## Configuration
- `BCD_COUNTER_WRAP_EN` defined: in DONE, `en` returns the value to 00 and the state to IDLE, so `done` is a pulse lasting until the next enabled edge. The next `en` after that yields 01. With no `en`, DONE holds.
- Undefined (default): DONE is sticky. `en` is ignored, the value stays `LIMIT`, and `done` stays 1 until `Error` or `reset`.

## Test plan
- Default `LIMIT`=99, `Bs`=1 held for 99 cycles → counts 01…99, `done`=1 from cycle 99, 9 `carry` pulses (at 10, 20, …, 90). Extra cycles leave it at 99 with `done`=1 (no WRAP_EN).
- Enable gaps: toggle `Vs` 1,0,0,1,1,0,1 with `Bs`=0 → value 04 after 7 edges, holding on the 0 cycles. `Bs`=`Vs`=1 for 3 edges → +3.
- `Error` at value 45 with `Bs`=1 → 00, state IDLE, `carry`=0. Keep `Error`=1 for 5 edges → stays 00. Release `Error` → 01 on the next edge.
- Async `reset` pulsed mid-cycle at value 37 → outputs 00, `done`=0 before the next `clock` edge. Then 3 enabled edges → 03.
- `LIMIT`=12 with `BCD_COUNTER_WRAP_EN` → `done`=1 at 12. The next enabled edge gives 00 with `done`=0, then 01 on the following one. The same stimulus without the macro gives 12 with `done`=1 for 20 further enabled cycles.
- `LIMIT`=1 → a single enabled edge from IDLE gives 01, state DONE, `done`=1.

Source files
------------

// File: rtl/bcd_counter_0to99_if.sv
// Request/abort inputs and BCD/status outputs of the 00-to-LIMIT BCD up-counter.
// The master side drives the requests; the counter itself is the slave.
interface bcd_counter_0to99_if;
  logic       Bs;
  logic       Vs;
  logic       Error;
  logic [3:0] bcd_units;
  logic [3:0] bcd_tens;
  logic       done;
  logic       carry;
  logic [1:0] state;

  modport master (
    output Bs, Vs, Error,
    input  bcd_units, bcd_tens, done, carry, state
  );

  modport slave (
    input  Bs, Vs, Error,
    output bcd_units, bcd_tens, done, carry, state
  );
endinterface

// File: rtl/bcd_counter_0to99.sv
// Two-digit BCD up-counter from 00 to LIMIT, gated by Bs/Vs and cleared by Error.
// Define BCD_COUNTER_WRAP_EN to let an enabled edge in DONE return the count to 00/IDLE.
module bcd_counter_0to99 #(
  parameter int LIMIT = 99
) (
  input  logic               clock,
  input  logic               reset,
  bcd_counter_0to99_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] LIM_TENS  = 4'(LIMIT / 10);
  localparam logic [3:0] LIM_UNITS = 4'(LIMIT % 10);

  state_t     state_q, state_d;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic       carry_q, carry_d;
  logic [3:0] inc_units, inc_tens;
  logic       inc_carry;
  logic       en;

  // Two simultaneous requests still give a single increment per edge.
  assign en = (bus.Bs | bus.Vs) & ~bus.Error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    inc_units = units_q;
    inc_tens  = tens_q;
    inc_carry = 1'b0;
    if (units_q == 4'd9) begin
      inc_units = 4'd0;
      inc_tens  = tens_q + 4'd1;
      inc_carry = 1'b1;
    end else begin
      inc_units = units_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (bus.Error) begin
      state_d = S_IDLE;
      units_d = 4'd0;
      tens_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            units_d = 4'd1;
            tens_d  = 4'd0;
            state_d = (LIMIT == 1) ? S_DONE : S_COUNT;
          end
        end
        S_COUNT: begin
          if (en) begin
            units_d = inc_units;
            tens_d  = inc_tens;
            carry_d = inc_carry;
            if (inc_units == LIM_UNITS && inc_tens == LIM_TENS) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
`ifdef BCD_COUNTER_WRAP_EN
          if (en) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
            state_d = S_IDLE;
          end
`else
          // Sticky: requests are ignored until Error or reset.
          state_d = S_DONE;
`endif
        end
        default: begin
          state_d = S_IDLE;
          units_d = 4'd0;
          tens_d  = 4'd0;
        end
      endcase
    end
  end

  assign bus.bcd_units = units_q;
  assign bus.bcd_tens  = tens_q;
  assign bus.carry     = carry_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bcd_counter_0to99.sv
// Directed bench for bcd_counter_0to99: LIMIT=99, 12 and 1 instances side by side.
module tb_bcd_counter_0to99;

  logic clock;
  logic reset;
  logic bs, vs, err;
  logic bs2, err2;
  int   tests;
  int   fails;
  int   carries;

  bcd_counter_0to99_if if99 ();
  bcd_counter_0to99_if if12 ();
  bcd_counter_0to99_if if1 ();

  assign if99.Bs    = bs;
  assign if99.Vs    = vs;
  assign if99.Error = err;
  assign if12.Bs    = bs2;
  assign if12.Vs    = 1'b0;
  assign if12.Error = err2;
  assign if1.Bs     = bs2;
  assign if1.Vs     = 1'b0;
  assign if1.Error  = err2;

  bcd_counter_0to99 #(.LIMIT(99)) dut99 (.clock(clock), .reset(reset), .bus(if99));
  bcd_counter_0to99 #(.LIMIT(12)) dut12 (.clock(clock), .reset(reset), .bus(if12));
  bcd_counter_0to99 #(.LIMIT(1))  dut1  (.clock(clock), .reset(reset), .bus(if1));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n is the decimal count shown on both digits
  task automatic chk99(input string tag, input int n, input int ed, input int ec, input int es);
    chk({tag, ".units"}, int'(if99.bcd_units), n % 10);
    chk({tag, ".tens"},  int'(if99.bcd_tens),  n / 10);
    chk({tag, ".done"},  int'(if99.done),      ed);
    chk({tag, ".carry"}, int'(if99.carry),     ec);
    chk({tag, ".state"}, int'(if99.state),     es);
  endtask

  task automatic chk12(input string tag, input int n, input int ed, input int ec, input int es);
    chk({tag, ".units"}, int'(if12.bcd_units), n % 10);
    chk({tag, ".tens"},  int'(if12.bcd_tens),  n / 10);
    chk({tag, ".done"},  int'(if12.done),      ed);
    chk({tag, ".carry"}, int'(if12.carry),     ec);
    chk({tag, ".state"}, int'(if12.state),     es);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    carries = 0;
    reset   = 1'b1;
    bs = 1'b0; vs = 1'b0; err = 1'b0;
    bs2 = 1'b0; err2 = 1'b0;
    #12;
    chk99("reset", 0, 0, 0, 0);
    chk12("reset12", 0, 0, 0, 0);
    reset = 1'b0;
    step();

    // full count 01..99 with Bs held
    bs = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      step();
      chk99($sformatf("count%0d", i), i, (i == 99) ? 1 : 0, (i % 10 == 0) ? 1 : 0, (i == 99) ? 2 : 1);
      if (if99.carry === 1'b1) carries++;
    end
    chk("carry_pulses", carries, 9);
`ifdef BCD_COUNTER_WRAP_EN
    step();
    chk99("wrap99", 0, 0, 0, 0);
    step();
    chk99("wrap99_next", 1, 0, 0, 1);
`else
    for (int i = 0; i < 5; i++) begin
      step();
      chk99($sformatf("sticky99_%0d", i), 99, 1, 0, 2);
    end
`endif
    bs = 1'b0; err = 1'b1;
    step();
    chk99("clear99", 0, 0, 0, 0);
    err = 1'b0;

    // enable gaps on Vs: 1,0,0,1,1,0,1 -> 1,1,1,2,3,3,4
    vs = 1'b1; step(); chk99("gap1", 1, 0, 0, 1);
    vs = 1'b0; step(); chk99("gap2", 1, 0, 0, 1);
    vs = 1'b0; step(); chk99("gap3", 1, 0, 0, 1);
    vs = 1'b1; step(); chk99("gap4", 2, 0, 0, 1);
    vs = 1'b1; step(); chk99("gap5", 3, 0, 0, 1);
    vs = 1'b0; step(); chk99("gap6", 3, 0, 0, 1);
    vs = 1'b1; step(); chk99("gap7", 4, 0, 0, 1);
    bs = 1'b1; vs = 1'b1;
    step(); chk99("both1", 5, 0, 0, 1);
    step(); chk99("both2", 6, 0, 0, 1);
    step(); chk99("both3", 7, 0, 0, 1);
    vs = 1'b0;

    // Error at 45 with Bs still high
    for (int i = 0; i < 38; i++) step();
    chk99("at45", 45, 0, 0, 1);
    err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk99($sformatf("err%0d", i), 0, 0, 0, 0);
    end
    err = 1'b0;
    step();
    chk99("resume", 1, 0, 0, 1);

    // async reset mid-cycle at 37
    for (int i = 0; i < 36; i++) step();
    chk99("at37", 37, 0, 0, 1);
    bs = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk99("async_rst", 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    bs = 1'b1;
    step(); step(); step();
    chk99("after_rst", 3, 0, 0, 1);
    bs = 1'b0;
    step(); step();
    chk99("hold", 3, 0, 0, 1);

    // LIMIT=12 instance
    bs2 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk12($sformatf("l12_%0d", i), i, (i == 12) ? 1 : 0, (i == 10) ? 1 : 0, (i == 12) ? 2 : 1);
    end
`ifdef BCD_COUNTER_WRAP_EN
    step();
    chk12("l12_wrap", 0, 0, 0, 0);
    step();
    chk12("l12_wrap_next", 1, 0, 0, 1);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk12($sformatf("l12_sticky%0d", i), 12, 1, 0, 2);
    end
`endif
    bs2 = 1'b0; err2 = 1'b1;
    step();
    chk12("l12_clear", 0, 0, 0, 0);
    chk("l1_clear.state", int'(if1.state), 0);
    err2 = 1'b0;

    // LIMIT=1: one enabled edge reaches DONE
    bs2 = 1'b1;
    step();
    bs2 = 1'b0;
    chk("l1.units", int'(if1.bcd_units), 1);
    chk("l1.tens",  int'(if1.bcd_tens),  0);
    chk("l1.done",  int'(if1.done),      1);
    chk("l1.state", int'(if1.state),     2);
    chk("l1.carry", int'(if1.carry),     0);
    step();
    chk("l1_hold.done", int'(if1.done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
